// File: rtl/operand_digit_decoder.sv
// operand_digit_decoder
// Splits a 16-bit calculator value into display digit codes, most significant
// digit first in the packed output. Hex mode gives the four nibbles in one
// conversion cycle. Decimal mode runs a shift-add-3 (double-dabble) loop, one
// input bit per clock, for 16 clocks. Start/done handshake; the last result is
// held until the next conversion completes.
//
// Build option: define LEADING_ZERO_BLANK_EN to output the blank code 5'h1F in
// the positions above the highest significant digit. Digit0 is never blanked.
module operand_digit_decoder (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        mode,
  input  logic [15:0] value,
  output logic        busy,
  output logic        done,
  output logic [24:0] digits,
  output logic [2:0]  ndigits
);

  localparam int WIDTH = 16;
  localparam int NDIG  = 5;

`ifdef LEADING_ZERO_BLANK_EN
  localparam logic [4:0]        BLANK      = 5'h1F;
  localparam logic [5*NDIG-1:0] DIGITS_RST = {BLANK, BLANK, BLANK, BLANK, 5'h00};
`else
  localparam logic [5*NDIG-1:0] DIGITS_RST = {5*NDIG{1'b0}};
`endif

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CONV = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t              state_q, state_d;
  logic                mode_q, mode_d;
  logic [WIDTH-1:0]    shreg_q, shreg_d;
  logic [4*NDIG-1:0]   bcd_q, bcd_d;
  logic [3:0]          cnt_q, cnt_d;
  logic [5*NDIG-1:0]   digits_q, digits_d;
  logic [2:0]          ndigits_q, ndigits_d;
  logic [4*NDIG-1:0]   bcd_adj_s;
  logic [4*NDIG-1:0]   result_s;

  // Add 3 to every BCD nibble that is 5 or more, ahead of the next left shift.
  function automatic logic [4*NDIG-1:0] add3_all(input logic [4*NDIG-1:0] b);
    logic [4*NDIG-1:0] r;
    r = b;
    for (int i = 0; i < NDIG; i++) begin
      if (b[4*i +: 4] >= 4'd5) begin
        r[4*i +: 4] = b[4*i +: 4] + 4'd3;
      end else begin
        r[4*i +: 4] = b[4*i +: 4];
      end
    end
    return r;
  endfunction

  // Significant digit count: index of highest nonzero nibble plus one, min 1.
  function automatic logic [2:0] count_digits(input logic [4*NDIG-1:0] d);
    logic [2:0] n;
    n = 3'd1;
    for (int i = 1; i < NDIG; i++) begin
      if (d[4*i +: 4] != 4'h0) begin
        n = 3'(i + 1);
      end else begin
        n = n;
      end
    end
    return n;
  endfunction

  // Widen 4-bit nibbles to 5-bit digit codes, blanking leading positions if enabled.
  function automatic logic [5*NDIG-1:0] pack_digits(input logic [4*NDIG-1:0] d);
    logic [5*NDIG-1:0] r;
`ifdef LEADING_ZERO_BLANK_EN
    logic [2:0] n;
    n = count_digits(d);
`endif
    for (int i = 0; i < NDIG; i++) begin
      r[5*i +: 5] = {1'b0, d[4*i +: 4]};
`ifdef LEADING_ZERO_BLANK_EN
      if ((i != 0) && (i >= int'(n))) begin
        r[5*i +: 5] = BLANK;
      end else begin
        r[5*i +: 5] = {1'b0, d[4*i +: 4]};
      end
`endif
    end
    return r;
  endfunction

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= S_IDLE;
      mode_q    <= 1'b0;
      shreg_q   <= {WIDTH{1'b0}};
      bcd_q     <= {4*NDIG{1'b0}};
      cnt_q     <= 4'd0;
      digits_q  <= DIGITS_RST;
      ndigits_q <= 3'd1;
    end else begin
      state_q   <= state_d;
      mode_q    <= mode_d;
      shreg_q   <= shreg_d;
      bcd_q     <= bcd_d;
      cnt_q     <= cnt_d;
      digits_q  <= digits_d;
      ndigits_q <= ndigits_d;
    end
  end

  // Next-state logic: capture on start, convert, publish the result entering DONE.
  always_comb begin
    state_d   = state_q;
    mode_d    = mode_q;
    shreg_d   = shreg_q;
    bcd_d     = bcd_q;
    cnt_d     = cnt_q;
    digits_d  = digits_q;
    ndigits_d = ndigits_q;
    bcd_adj_s = add3_all(bcd_q);
    result_s  = {4*NDIG{1'b0}};
    case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          mode_d  = mode;
          shreg_d = value;
          bcd_d   = {4*NDIG{1'b0}};
          cnt_d   = 4'd15;
          state_d = S_CONV;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_CONV: begin
        if (!mode_q) begin
          // Hex: the captured value already is the nibble string.
          result_s  = {4'h0, shreg_q};
          digits_d  = pack_digits(result_s);
          ndigits_d = count_digits(result_s);
          state_d   = S_DONE;
        end else begin
          // Decimal: adjust, then shift {bcd, shreg} left by one bit.
          bcd_d   = {bcd_adj_s[4*NDIG-2:0], shreg_q[WIDTH-1]};
          shreg_d = {shreg_q[WIDTH-2:0], 1'b0};
          cnt_d   = cnt_q - 4'd1;
          if (cnt_q == 4'd0) begin
            result_s  = bcd_d;
            digits_d  = pack_digits(result_s);
            ndigits_d = count_digits(result_s);
            state_d   = S_DONE;
          end else begin
            state_d = S_CONV;
          end
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  assign busy    = (state_q == S_CONV);
  assign done    = (state_q == S_DONE);
  assign digits  = digits_q;
  assign ndigits = ndigits_q;

endmodule
